// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle RV32I-subset core (R-type, I-type ALU, LW, SW,
// BEQ, JAL). It runs one phase per cycle: FETCH, DECODE, EXEC, then optionally
// MEM and/or WB. It drives the datapath strobes and the instruction and data
// memory request lines.
//
// Handshake: a request (imem_req / dmem_req) is held high until the matching
// ready is seen high in a cycle where the request is also high. That cycle
// completes the transfer, and the FSM leaves the state on the next edge. If
// no ready arrives within MEM_TIMEOUT request cycles, bus_err is set and the
// FSM parks in TRAP. A ready in the last allowed cycle still completes the
// transfer.
//
// Parameters
//   MEM_TIMEOUT  request cycles allowed before a bus-error trap (1..255)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   opcode[6:0]  instr[6:0] from the instruction register
//   zero         ALU zero flag (BEQ outcome)
//   imem_ready   instruction memory has data / accepted request
//   dmem_ready   data memory completed the access
//   imem_req     instruction fetch request
//   dmem_req     data memory request
//   dmem_we      data memory write (store)
//   ir_we        instruction register load strobe
//   pc_we        PC update strobe
//   pc_sel       0 = PC+4, 1 = branch/jump target
//   we           register file write enable
//   alu_op[1:0]  ALUOp to ALU control (00 add, 01 sub/compare, 10 funct)
//   alu_src      0 = rd2, 1 = immediate
//   wb_sel[1:0]  00 = ALU result, 01 = load data, 10 = PC+4
//   retire       one-cycle pulse per completed instruction
//   illegal      sticky illegal-opcode trap flag
//   bus_err      sticky memory-timeout trap flag
//   state[2:0]   current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       ir_we,
   output logic       pc_we,
   output logic       pc_sel,
   output logic       we,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic [1:0] wb_sel,
   output logic       retire,
   output logic       illegal,
   output logic       bus_err,
   output logic [2:0] state
);

   // Counter must be able to hold MEM_TIMEOUT itself.
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   // Value seen in the last request cycle allowed before the trap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LW  = 7'b0000011;
   localparam logic [6:0] OPC_SW  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;
   localparam logic [6:0] OPC_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CL_R   = 3'd0,
      CL_I   = 3'd1,
      CL_LW  = 3'd2,
      CL_SW  = 3'd3,
      CL_BEQ = 3'd4,
      CL_JAL = 3'd5
   } op_class_e;

   state_e           state_q, state_d;
   op_class_e        class_q, class_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;

   // A request is outstanding in this cycle and no ready has come back.
   logic             req_waiting;
   // This is the last request cycle allowed; no ready means trap.
   logic             timeout_hit;

   assign req_waiting = ((state_q == S_FETCH) && !imem_ready) ||
                        ((state_q == S_MEM)   && !dmem_ready);
   assign timeout_hit = (cnt_q == CNT_LAST);

   // ---------------------------------------------------------------------------
   // State and status registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         class_q   <= CL_R;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Timeout counter. It only runs while a request is left waiting. It clears
   // on every state change, so a fresh request always starts at zero.
   // ---------------------------------------------------------------------------
   always_comb begin
      cnt_d = cnt_q;
      if ((state_d != state_q) || !req_waiting) begin
         cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and outputs. The strobes follow the current state and the
   // latched opcode class. The only input-dependent strobes are the ones that
   // fire in the handshake-completion cycle, plus pc_sel for BEQ.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      we        = 1'b0;
      alu_op    = 2'b00;
      alu_src   = 1'b0;
      wb_sel    = 2'b00;
      retire    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               // The IR captures the word in the same cycle the memory
               // presents it.
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end
         end

         S_DECODE: begin
            state_d = S_EXEC;
            unique case (opcode)
               OPC_R:   class_d = CL_R;
               OPC_I:   class_d = CL_I;
               OPC_LW:  class_d = CL_LW;
               OPC_SW:  class_d = CL_SW;
               OPC_BEQ: class_d = CL_BEQ;
               OPC_JAL: class_d = CL_JAL;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_TRAP;
               end
            endcase
         end

         S_EXEC: begin
            unique case (class_q)
               CL_R: begin
                  alu_op  = 2'b10;
                  state_d = S_WB;
               end
               CL_I: begin
                  alu_op  = 2'b10;
                  alu_src = 1'b1;
                  state_d = S_WB;
               end
               CL_LW, CL_SW: begin
                  // Address = rs1 + imm.
                  alu_src = 1'b1;
                  state_d = S_MEM;
               end
               CL_BEQ: begin
                  // The compare result decides the PC source in this cycle,
                  // so a branch retires without a WB phase.
                  alu_op  = 2'b01;
                  pc_we   = 1'b1;
                  pc_sel  = zero;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               CL_JAL: begin
                  state_d = S_WB;
               end
               default: begin
                  state_d = S_TRAP;
               end
            endcase
         end

         S_MEM: begin
            // Keep the address computation stable for the whole access.
            alu_src  = 1'b1;
            dmem_req = 1'b1;
            dmem_we  = (class_q == CL_SW);
            if (dmem_ready) begin
               if (class_q == CL_SW) begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end
         end

         S_WB: begin
            we      = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
            unique case (class_q)
               CL_LW:  wb_sel = 2'b01;
               CL_JAL: begin
                  wb_sel = 2'b10;
                  pc_sel = 1'b1;
               end
               default: wb_sel = 2'b00;
            endcase
         end

         S_TRAP: begin
            state_d = S_TRAP;
         end

         default: begin
            // Unused encoding: fail safe into the trap state.
            state_d = S_TRAP;
         end
      endcase
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;
   assign state   = state_q;

   // ---------------------------------------------------------------------------
   // Structural invariants of the sequencer
   // ---------------------------------------------------------------------------
   a_req_exclusive: assert property (@(posedge clk) disable iff (!reset)
      !(imem_req && dmem_req));

   a_we_only_wb: assert property (@(posedge clk) disable iff (!reset)
      we |-> (state_q == S_WB));

   a_pc_we_states: assert property (@(posedge clk) disable iff (!reset)
      pc_we |-> ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)));

   a_trap_sticky: assert property (@(posedge clk) disable iff (!reset)
      (state_q == S_TRAP) |=> (state_q == S_TRAP));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl, built with MEM_TIMEOUT = 4. Each cycle
// the bench sets the inputs, lets the combinational outputs settle, compares
// the state and a packed output vector with hand-written values, then moves to
// the next rising edge. Inputs change 2 time units after the edge and are
// sampled 1 unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int unsigned TO = 4;

   // Packed output vector:
   // {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, we,
   //  alu_op[1:0], alu_src, wb_sel[1:0], retire, illegal, bus_err}
   localparam logic [14:0] M_IMEM   = 15'h4000;
   localparam logic [14:0] M_DMEM   = 15'h2000;
   localparam logic [14:0] M_DWE    = 15'h1000;
   localparam logic [14:0] M_IRWE   = 15'h0800;
   localparam logic [14:0] M_PCWE   = 15'h0400;
   localparam logic [14:0] M_PCSEL  = 15'h0200;
   localparam logic [14:0] M_WE     = 15'h0100;
   localparam logic [14:0] M_AOP_F  = 15'h0080;  // alu_op = 10
   localparam logic [14:0] M_AOP_S  = 15'h0040;  // alu_op = 01
   localparam logic [14:0] M_SRC    = 15'h0020;
   localparam logic [14:0] M_WB_PC  = 15'h0010;  // wb_sel = 10
   localparam logic [14:0] M_WB_LD  = 15'h0008;  // wb_sel = 01
   localparam logic [14:0] M_RET    = 15'h0004;
   localparam logic [14:0] M_ILL    = 15'h0002;
   localparam logic [14:0] M_BERR   = 15'h0001;
   localparam logic [14:0] M_NONE   = 15'h0000;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FET  = 3'd1;
   localparam logic [2:0] ST_DEC  = 3'd2;
   localparam logic [2:0] ST_EXE  = 3'd3;
   localparam logic [2:0] ST_MEM  = 3'd4;
   localparam logic [2:0] ST_WB   = 3'd5;
   localparam logic [2:0] ST_TRAP = 3'd7;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] opcode = '0;
   logic       zero = 1'b0;
   logic       imem_ready = 1'b0;
   logic       dmem_ready = 1'b0;
   logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, we;
   logic [1:0] alu_op, wb_sel;
   logic       alu_src, retire, illegal, bus_err;
   logic [2:0] state;
   logic [14:0] outs;

   assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, we,
                  alu_op, alu_src, wb_sel, retire, illegal, bus_err};

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .zero       (zero),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_sel     (pc_sel),
      .we         (we),
      .alu_op     (alu_op),
      .alu_src    (alu_src),
      .wb_sel     (wb_sel),
      .retire     (retire),
      .illegal    (illegal),
      .bus_err    (bus_err),
      .state      (state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   // Check the current cycle, then advance to 2 units past the next edge.
   task automatic cyc(input string tag, input logic [2:0] st,
                      input logic [14:0] vec);
      #1;
      check({tag, ".state"}, 32'(state), 32'(st));
      check({tag, ".outs"},  32'(outs),  32'(vec));
      @(posedge clk);
      #2;
   endtask

   task automatic go_reset();
      reset = 1'b0;
      cyc("rst_hold", ST_IDLE, M_NONE);
      reset = 1'b1;
      cyc("rst_idle", ST_IDLE, M_NONE);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      imem_ready = 1'b1;
      @(posedge clk);
      #2;
      cyc("por", ST_IDLE, M_NONE);
      reset = 1'b1;
      cyc("idle", ST_IDLE, M_NONE);

      // R-type, ready everywhere.
      opcode = OP_R;
      cyc("r_fetch", ST_FET, M_IMEM | M_IRWE);
      cyc("r_dec",   ST_DEC, M_NONE);
      cyc("r_exec",  ST_EXE, M_AOP_F);
      cyc("r_wb",    ST_WB,  M_WE | M_PCWE | M_RET);

      // LW with dmem_ready on the 4th MEM cycle (also the last allowed one).
      opcode = OP_LW;
      cyc("lw_fetch", ST_FET, M_IMEM | M_IRWE);
      cyc("lw_dec",   ST_DEC, M_NONE);
      cyc("lw_exec",  ST_EXE, M_SRC);
      dmem_ready = 1'b0;
      cyc("lw_mem1",  ST_MEM, M_DMEM | M_SRC);
      cyc("lw_mem2",  ST_MEM, M_DMEM | M_SRC);
      cyc("lw_mem3",  ST_MEM, M_DMEM | M_SRC);
      dmem_ready = 1'b1;
      cyc("lw_mem4",  ST_MEM, M_DMEM | M_SRC);
      dmem_ready = 1'b0;
      cyc("lw_wb",    ST_WB,  M_WE | M_PCWE | M_RET | M_WB_LD);

      // SW, immediate ready.
      opcode = OP_SW;
      cyc("sw_fetch", ST_FET, M_IMEM | M_IRWE);
      cyc("sw_dec",   ST_DEC, M_NONE);
      cyc("sw_exec",  ST_EXE, M_SRC);
      dmem_ready = 1'b1;
      cyc("sw_mem",   ST_MEM, M_DMEM | M_DWE | M_SRC | M_PCWE | M_RET);
      dmem_ready = 1'b0;

      // BEQ taken.
      opcode = OP_BEQ;
      zero   = 1'b1;
      cyc("beq1_fetch", ST_FET, M_IMEM | M_IRWE);
      cyc("beq1_dec",   ST_DEC, M_NONE);
      cyc("beq1_exec",  ST_EXE, M_AOP_S | M_PCWE | M_PCSEL | M_RET);

      // BEQ not taken.
      zero = 1'b0;
      cyc("beq0_fetch", ST_FET, M_IMEM | M_IRWE);
      cyc("beq0_dec",   ST_DEC, M_NONE);
      cyc("beq0_exec",  ST_EXE, M_AOP_S | M_PCWE | M_RET);

      // JAL.
      opcode = OP_JAL;
      cyc("jal_fetch", ST_FET, M_IMEM | M_IRWE);
      cyc("jal_dec",   ST_DEC, M_NONE);
      cyc("jal_exec",  ST_EXE, M_NONE);
      cyc("jal_wb",    ST_WB,  M_WE | M_PCWE | M_PCSEL | M_RET | M_WB_PC);

      // Fetch ready on the last allowed cycle: accepted, no trap.
      opcode     = OP_R;
      imem_ready = 1'b0;
      cyc("fw_f1", ST_FET, M_IMEM);
      cyc("fw_f2", ST_FET, M_IMEM);
      cyc("fw_f3", ST_FET, M_IMEM);
      imem_ready = 1'b1;
      cyc("fw_f4", ST_FET, M_IMEM | M_IRWE);
      cyc("fw_dec",  ST_DEC, M_NONE);
      cyc("fw_exec", ST_EXE, M_AOP_F);
      cyc("fw_wb",   ST_WB,  M_WE | M_PCWE | M_RET);

      // Illegal opcode: trap after DECODE, then fetch readies are ignored.
      opcode = OP_BAD;
      cyc("ill_fetch", ST_FET,  M_IMEM | M_IRWE);
      cyc("ill_dec",   ST_DEC,  M_NONE);
      cyc("ill_trap1", ST_TRAP, M_ILL);
      imem_ready = 1'b0;
      cyc("ill_trap2", ST_TRAP, M_ILL);
      imem_ready = 1'b1;
      cyc("ill_trap3", ST_TRAP, M_ILL);
      go_reset();

      // Fetch timeout: no ready for 4 cycles.
      opcode     = OP_R;
      imem_ready = 1'b0;
      cyc("fto_f1", ST_FET, M_IMEM);
      cyc("fto_f2", ST_FET, M_IMEM);
      cyc("fto_f3", ST_FET, M_IMEM);
      cyc("fto_f4", ST_FET, M_IMEM);
      cyc("fto_trap1", ST_TRAP, M_BERR);
      imem_ready = 1'b1;
      cyc("fto_trap2", ST_TRAP, M_BERR);
      go_reset();

      // Data-memory timeout on LW.
      opcode = OP_LW;
      cyc("mto_fetch", ST_FET, M_IMEM | M_IRWE);
      cyc("mto_dec",   ST_DEC, M_NONE);
      cyc("mto_exec",  ST_EXE, M_SRC);
      cyc("mto_m1",    ST_MEM, M_DMEM | M_SRC);
      cyc("mto_m2",    ST_MEM, M_DMEM | M_SRC);
      cyc("mto_m3",    ST_MEM, M_DMEM | M_SRC);
      cyc("mto_m4",    ST_MEM, M_DMEM | M_SRC);
      cyc("mto_trap",  ST_TRAP, M_BERR);
      go_reset();

      // Asynchronous reset in the middle of MEM: outputs drop before any edge.
      opcode = OP_SW;
      cyc("ar_fetch", ST_FET, M_IMEM | M_IRWE);
      cyc("ar_dec",   ST_DEC, M_NONE);
      cyc("ar_exec",  ST_EXE, M_SRC);
      cyc("ar_mem1",  ST_MEM, M_DMEM | M_DWE | M_SRC);
      reset = 1'b0;
      cyc("ar_async", ST_IDLE, M_NONE);
      reset = 1'b1;
      cyc("ar_idle",  ST_IDLE, M_NONE);
      cyc("ar_refetch", ST_FET, M_IMEM | M_IRWE);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   // Run-time bound in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
